ula_seq: RTL and testbench

- Sequencer that owns a small register file and drives the 8-bit ALU (op codes 000 pass A, 001 add, 010 and, 011 or, 100 sub, 101 neg, 110 not).
- Accepts one instruction at a time over a valid/ready handshake, then reads operands, drives the ALU, and writes the result back.
- Sits between the instruction source and the ALU instance.
- The ALU is an external, purely combinational instance: this block drives its op, A and B inputs and samples its result.

---
 rtl/ula_seq.sv | 153 +++++++++++++++
 tb/tb_ula_seq.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_seq.sv
// Instruction sequencer for an external combinational 8-bit ALU: accepts one
// instruction, reads its operands from a small register file, runs the ALU and writes the result back.
module ula_seq #(
   parameter int AW = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          instr_valid,
   output logic          instr_ready,
   input  logic [2:0]    instr_op,
   input  logic [AW-1:0] instr_rd,
   input  logic [AW-1:0] instr_rs,
   input  logic [AW-1:0] instr_rt,
   input  logic [7:0]    instr_imm,
   output logic [2:0]    ula_op,
   output logic [7:0]    ula_a,
   output logic [7:0]    ula_b,
   input  logic [7:0]    ula_res,
   output logic          done,
   output logic [7:0]    done_data,
   output logic          zero,
   input  logic [AW-1:0] dbg_addr,
   output logic [7:0]    dbg_data,
   output logic [1:0]    dbg_state
);

   localparam int NREG = 2 ** AW;
   localparam logic [2:0] OP_PASS = 3'b000;
   localparam logic [2:0] OP_LOAD = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_READ = 2'd1,
      S_EXEC = 2'd2,
      S_WB   = 2'd3
   } state_t;

   // Handshake: an instruction transfers on a rising edge where instr_valid and
   // instr_ready are both high; instr_ready is high only in IDLE outside reset.

   state_t          state_q, state_d;
   logic [2:0]      op_q, op_d;
   logic [AW-1:0]   rd_q, rd_d;
   logic [AW-1:0]   rs_q, rs_d;
   logic [AW-1:0]   rt_q, rt_d;
   logic [7:0]      imm_q, imm_d;
   logic [2:0]      ula_op_q, ula_op_d;
   logic [7:0]      ula_a_q, ula_a_d;
   logic [7:0]      ula_b_q, ula_b_d;
   logic [7:0]      res_q, res_d;
   logic            done_q, done_d;
   logic [7:0]      done_data_q, done_data_d;
   logic            zero_q, zero_d;
   logic [7:0]      rf_q [NREG];
   logic [7:0]      rf_d [NREG];

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      rd_d        = rd_q;
      rs_d        = rs_q;
      rt_d        = rt_q;
      imm_d       = imm_q;
      ula_op_d    = ula_op_q;
      ula_a_d     = ula_a_q;
      ula_b_d     = ula_b_q;
      res_d       = res_q;
      done_d      = 1'b0;
      done_data_d = done_data_q;
      zero_d      = zero_q;
      rf_d        = rf_q;

      case (state_q)
         S_IDLE: begin
            if (instr_valid) begin
               op_d    = instr_op;
               rd_d    = instr_rd;
               rs_d    = instr_rs;
               rt_d    = instr_rt;
               imm_d   = instr_imm;
               state_d = S_READ;
            end
         end
         S_READ: begin
            // The ALU operand registers double as the operand latches; LOAD runs as a pass of imm.
            ula_a_d  = (op_q == OP_LOAD) ? imm_q : rf_q[rs_q];
            ula_b_d  = rf_q[rt_q];
            ula_op_d = (op_q == OP_LOAD) ? OP_PASS : op_q;
            state_d  = S_EXEC;
         end
         S_EXEC: begin
            res_d    = ula_res;
            ula_op_d = OP_PASS;
            ula_a_d  = 8'h00;
            ula_b_d  = 8'h00;
            done_d   = 1'b1;
            state_d  = S_WB;
         end
         S_WB: begin
            rf_d[rd_q]  = res_q;
            done_data_d = res_q;
            zero_d      = (res_q == 8'h00);
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         op_q        <= 3'b000;
         rd_q        <= '0;
         rs_q        <= '0;
         rt_q        <= '0;
         imm_q       <= 8'h00;
         ula_op_q    <= OP_PASS;
         ula_a_q     <= 8'h00;
         ula_b_q     <= 8'h00;
         res_q       <= 8'h00;
         done_q      <= 1'b0;
         done_data_q <= 8'h00;
         zero_q      <= 1'b0;
         for (int i = 0; i < NREG; i++) rf_q[i] <= 8'h00;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         rd_q        <= rd_d;
         rs_q        <= rs_d;
         rt_q        <= rt_d;
         imm_q       <= imm_d;
         ula_op_q    <= ula_op_d;
         ula_a_q     <= ula_a_d;
         ula_b_q     <= ula_b_d;
         res_q       <= res_d;
         done_q      <= done_d;
         done_data_q <= done_data_d;
         zero_q      <= zero_d;
         rf_q        <= rf_d;
      end
   end

   assign instr_ready = (state_q == S_IDLE) && !reset;
   assign ula_op      = ula_op_q;
   assign ula_a       = ula_a_q;
   assign ula_b       = ula_b_q;
   assign done        = done_q;
   assign done_data   = done_data_q;
   assign zero        = zero_q;
   assign dbg_data    = rf_q[dbg_addr];
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_ula_seq.sv
// Self-checking bench for ula_seq: directed ALU cases, back-to-back accepts,
// reset mid-operation and randomized instructions against a register-file model.
module tb_ula_seq;

   localparam int AW   = 2;
   localparam int NREG = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          instr_valid;
   logic          instr_ready;
   logic [2:0]    instr_op;
   logic [AW-1:0] instr_rd, instr_rs, instr_rt;
   logic [7:0]    instr_imm;
   logic [2:0]    ula_op;
   logic [7:0]    ula_a, ula_b, ula_res;
   logic          done;
   logic [7:0]    done_data;
   logic          zero;
   logic [AW-1:0] dbg_addr;
   logic [7:0]    dbg_data;
   logic [1:0]    dbg_state;

   int vectors = 0;
   int miscompares = 0;
   logic [7:0] rf_model [NREG];
   logic [7:0] exp_q [$];

   always #5 clk = ~clk;

   ula_seq #(.AW(AW)) dut (
      .clk(clk), .reset(reset),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs(instr_rs),
      .instr_rt(instr_rt), .instr_imm(instr_imm),
      .ula_op(ula_op), .ula_a(ula_a), .ula_b(ula_b), .ula_res(ula_res),
      .done(done), .done_data(done_data), .zero(zero),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_state(dbg_state)
   );

   // Stand-in for the external combinational ALU.
   function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         3'd0: return a;
         3'd1: return a + b;
         3'd2: return a & b;
         3'd3: return a | b;
         3'd4: return a - b;
         3'd5: return 8'h00 - a;
         3'd6: return ~a;
         default: return 8'hXX;
      endcase
   endfunction

   assign ula_res = alu_f(ula_op, ula_a, ula_b);

   // Architectural result of one instruction given the current register file.
   function automatic logic [7:0] model_result(input logic [2:0] op, input logic [AW-1:0] rs,
                                               input logic [AW-1:0] rt, input logic [7:0] imm);
      int x, y;
      x = rf_model[rs];
      y = rf_model[rt];
      case (op)
         3'd0: return 8'(x);
         3'd1: return 8'((x + y) % 256);
         3'd2: return 8'(x & y);
         3'd3: return 8'(x | y);
         3'd4: return 8'((x - y + 256) % 256);
         3'd5: return 8'((256 - x) % 256);
         3'd6: return 8'(255 - x);
         default: return imm;
      endcase
   endfunction

   task automatic scramble_fields();
      instr_op  = 3'($urandom);
      instr_rd  = AW'($urandom);
      instr_rs  = AW'($urandom);
      instr_rt  = AW'($urandom);
      instr_imm = 8'($urandom);
   endtask

   task automatic run_instr(input logic [2:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs,
                            input logic [AW-1:0] rt, input logic [7:0] imm);
      logic [7:0] exp_res, exp_a, exp_b;
      logic [2:0] exp_op;
      int guard;
      exp_res = model_result(op, rs, rt, imm);
      exp_op  = (op == 3'b111) ? 3'b000 : op;
      exp_a   = (op == 3'b111) ? imm : rf_model[rs];
      exp_b   = rf_model[rt];
      @(negedge clk);
      instr_op = op; instr_rd = rd; instr_rs = rs; instr_rt = rt; instr_imm = imm;
      instr_valid = 1'b1;
      guard = 0;
      while (!instr_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      vectors++;
      if (instr_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL accept_wait: instr_ready=%b, required 1 within 20 cycles", instr_ready);
         instr_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      scramble_fields();
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || instr_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL read_cycle: done=%b ready=%b, required 0 0", done, instr_ready);
      end
      @(negedge clk);
      vectors++;
      if (ula_op !== exp_op || ula_a !== exp_a || ula_b !== exp_b) begin
         miscompares++;
         $display("FAIL exec_drive: op=%0d a=%h b=%h, required op=%0d a=%h b=%h",
                  ula_op, ula_a, ula_b, exp_op, exp_a, exp_b);
      end
      @(negedge clk);
      vectors++;
      if (done !== 1'b1) begin
         miscompares++;
         $display("FAIL wb_done: done=%b, required 1", done);
      end
      @(negedge clk);
      rf_model[rd] = exp_res;
      vectors++;
      if (done !== 1'b0 || done_data !== exp_res || zero !== (exp_res == 8'h00) || instr_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL writeback: done=%b data=%h zero=%b ready=%b, required 0 %h %b 1",
                  done, done_data, zero, instr_ready, exp_res, exp_res == 8'h00);
      end
      dbg_addr = rd;
      #1;
      vectors++;
      if (dbg_data !== exp_res) begin
         miscompares++;
         $display("FAIL dbg_rd: rf[%0d]=%h, required %h", rd, dbg_data, exp_res);
      end
   endtask

   task automatic dbg_sweep_zero(input string tag);
      for (int i = 0; i < NREG; i++) begin
         dbg_addr = AW'(i);
         #1;
         vectors++;
         if (dbg_data !== 8'h00) begin
            miscompares++;
            $display("FAIL %s: rf[%0d]=%h, required 00", tag, i, dbg_data);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      instr_valid = 1'b0;
      dbg_addr = '0;
      scramble_fields();
      repeat (3) @(negedge clk);
      vectors++;
      if (instr_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL ready_in_reset: instr_ready=%b, required 0", instr_ready);
      end
      reset = 1'b0;
      #1;
      vectors++;
      if (instr_ready !== 1'b1 || done !== 1'b0 || zero !== 1'b0 || done_data !== 8'h00 ||
          ula_op !== 3'b000 || ula_a !== 8'h00 || ula_b !== 8'h00) begin
         miscompares++;
         $display("FAIL reset_state: ready=%b done=%b zero=%b data=%h op=%0d a=%h b=%h, required 1 0 0 00 0 00 00",
                  instr_ready, done, zero, done_data, ula_op, ula_a, ula_b);
      end
      for (int i = 0; i < NREG; i++) rf_model[i] = 8'h00;
      dbg_sweep_zero("reset_rf");
   endtask

   task automatic test_load_add();
      run_instr(3'b111, 2'd1, AW'($urandom), AW'($urandom), 8'h05);
      run_instr(3'b111, 2'd2, AW'($urandom), AW'($urandom), 8'h03);
      run_instr(3'b001, 2'd3, 2'd1, 2'd2, 8'h00);
      vectors++;
      if (done_data !== 8'h08 || zero !== 1'b0) begin
         miscompares++;
         $display("FAIL add_const: data=%h zero=%b, required 08 0", done_data, zero);
      end
   endtask

   task automatic test_alu_ops();
      logic [7:0] want [6];
      want = '{8'hFE, 8'h00, 8'h01, 8'h07, 8'hFA, 8'h80};
      run_instr(3'b100, 2'd0, 2'd2, 2'd1, 8'h00);
      vectors++;
      if (done_data !== want[0]) begin miscompares++; $display("FAIL sub_wrap: %h, required %h", done_data, want[0]); end
      run_instr(3'b100, 2'd0, 2'd1, 2'd1, 8'h00);
      vectors++;
      if (done_data !== want[1] || zero !== 1'b1) begin
         miscompares++;
         $display("FAIL sub_zero: data=%h zero=%b, required %h 1", done_data, zero, want[1]);
      end
      run_instr(3'b010, 2'd3, 2'd1, 2'd2, 8'h00);
      vectors++;
      if (done_data !== want[2]) begin miscompares++; $display("FAIL and_op: %h, required %h", done_data, want[2]); end
      run_instr(3'b011, 2'd3, 2'd1, 2'd2, 8'h00);
      vectors++;
      if (done_data !== want[3]) begin miscompares++; $display("FAIL or_op: %h, required %h", done_data, want[3]); end
      run_instr(3'b110, 2'd3, 2'd1, 2'd0, 8'h00);
      vectors++;
      if (done_data !== want[4]) begin miscompares++; $display("FAIL not_op: %h, required %h", done_data, want[4]); end
      run_instr(3'b111, 2'd2, 2'd0, 2'd0, 8'h80);
      run_instr(3'b101, 2'd2, 2'd2, 2'd2, 8'h00);
      vectors++;
      if (done_data !== want[5]) begin miscompares++; $display("FAIL neg_80: %h, required %h", done_data, want[5]); end
   endtask

   task automatic test_back_to_back();
      logic [2:0]    ops [3];
      logic [AW-1:0] rds [3], rss [3], rts [3];
      logic [7:0]    imms [3];
      int acc [$];
      int dn [$];
      int idx;
      logic prev_done, check_data;
      for (int i = 0; i < 3; i++) begin
         ops[i] = 3'($urandom_range(0, 7));
         rds[i] = AW'($urandom); rss[i] = AW'($urandom); rts[i] = AW'($urandom);
         imms[i] = 8'($urandom);
      end
      @(negedge clk);
      idx = 0;
      instr_op = ops[0]; instr_rd = rds[0]; instr_rs = rss[0]; instr_rt = rts[0]; instr_imm = imms[0];
      instr_valid = 1'b1;
      prev_done = 1'b0;
      check_data = 1'b0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         if (check_data) begin
            vectors++;
            if (exp_q.size() == 0 || done_data !== exp_q[0]) begin
               miscompares++;
               $display("FAIL b2b_data: cycle %0d data=%h, required %h", cyc, done_data,
                        (exp_q.size() != 0) ? exp_q[0] : 8'hXX);
            end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
         end
         check_data = done;
         if (done) begin
            dn.push_back(cyc);
            vectors++;
            if (prev_done) begin
               miscompares++;
               $display("FAIL b2b_width: done high two cycles running at cycle %0d, required 1-cycle pulse", cyc);
            end
         end
         prev_done = done;
         if (instr_valid && instr_ready) begin
            acc.push_back(cyc);
            exp_q.push_back(model_result(ops[idx], rss[idx], rts[idx], imms[idx]));
            rf_model[rds[idx]] = exp_q[$];
            idx++;
         end
         @(posedge clk);
         #1;
         if (idx < 3) begin
            instr_op = ops[idx]; instr_rd = rds[idx]; instr_rs = rss[idx]; instr_rt = rts[idx]; instr_imm = imms[idx];
         end else begin
            instr_valid = 1'b0;
            scramble_fields();
         end
         @(negedge clk);
      end
      vectors++;
      if (acc.size() != 3 || dn.size() != 3) begin
         miscompares++;
         $display("FAIL b2b_count: accepts=%0d dones=%0d, required 3 3", acc.size(), dn.size());
      end else begin
         for (int i = 1; i < 3; i++) begin
            vectors++;
            if (acc[i] - acc[i-1] != 4 || dn[i] - dn[i-1] != 4) begin
               miscompares++;
               $display("FAIL b2b_spacing: accept gap=%0d done gap=%0d, required 4 4",
                        acc[i] - acc[i-1], dn[i] - dn[i-1]);
            end
         end
         vectors++;
         if (dn[0] - acc[0] != 3) begin
            miscompares++;
            $display("FAIL b2b_latency: %0d cycles accept to done, required 3", dn[0] - acc[0]);
         end
      end
      exp_q.delete();
   endtask

   task automatic test_reset_mid();
      run_instr(3'b111, 2'd1, 2'd0, 2'd0, 8'($urandom_range(1, 255)));
      run_instr(3'b111, 2'd2, 2'd0, 2'd0, 8'($urandom_range(1, 255)));
      run_instr(3'b111, 2'd3, 2'd0, 2'd0, 8'h00);
      @(negedge clk);
      instr_op = 3'b001; instr_rd = 2'd3; instr_rs = 2'd1; instr_rt = 2'd2; instr_imm = 8'h00;
      instr_valid = 1'b1;
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      vectors++;
      if (ula_op !== 3'b001) begin
         miscompares++;
         $display("FAIL mid_exec_op: ula_op=%0d, required 1", ula_op);
      end
      reset = 1'b1;
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || instr_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_reset: done=%b ready=%b, required 0 0", done, instr_ready);
      end
      reset = 1'b0;
      #1;
      vectors++;
      if (instr_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL ready_after_reset: instr_ready=%b, required 1", instr_ready);
      end
      for (int i = 0; i < NREG; i++) rf_model[i] = 8'h00;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         vectors++;
         if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL abandoned_done: done=%b at cycle %0d after reset, required 0", done, i);
         end
      end
      dbg_sweep_zero("mid_reset_rf");
      run_instr(3'b111, 2'd0, 2'd0, 2'd0, 8'h5A);
   endtask

   task automatic test_random();
      for (int n = 0; n < 40; n++) begin
         run_instr(3'($urandom_range(0, 7)), AW'($urandom), AW'($urandom), AW'($urandom), 8'($urandom));
      end
   endtask

   initial begin
      test_reset();
      test_load_add();
      test_alu_ops();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded 200000 time units, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
